// File: rtl/tx_uart_echo_if.sv
// Frame strobe from the UART receiver into the echo block.
// Strobe-only handshake: frame is meaningful only on cycles where frame_valid=1; there is no ready, the consumer always samples it.
interface tx_uart_echo_if;
    logic       frame_valid;
    logic [9:0] frame;

    modport master (output frame_valid, output frame);
    modport slave  (input  frame_valid, input  frame);
endinterface

// File: rtl/tx_uart_echo.sv
// Echo path: checks received frames, buffers good bytes in a FIFO, and re-sends them 8N1.
// Debug outputs expose FIFO occupancy, overflow, framing-error count and the TX FSM state.
module tx_uart_echo #(
    parameter int TIMER_BITS      = 10,
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int FIFO_AW         = 4
) (
    input  logic               clk,
    input  logic               i_reset,
    tx_uart_echo_if.slave      rx,
    output logic               o_uart_tx,
    output logic               o_busy,
    output logic [FIFO_AW:0]   o_fifo_count,
    output logic               o_overflow,
    output logic [7:0]         o_frame_err,
    output logic [1:0]         o_state
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [TIMER_BITS-1:0] RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_d;
    logic [TIMER_BITS-1:0] baud, baud_d;
    logic [2:0]            idx, idx_d;
    logic [7:0]            sh, sh_d;
    logic                  tx_d, busy_d;

    logic [7:0]            mem [DEPTH];
    logic [FIFO_AW:0]      wr_ptr, rd_ptr, count;
    logic                  full, empty, frame_ok, frame_bad, push, pop;

    assign full      = (count == (FIFO_AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign frame_ok  = !rx.frame[0] && rx.frame[9];
    assign frame_bad = (rx.frame != 10'h3FF) && !frame_ok;
    // A push on a full FIFO is dropped even when the FSM pops on the same edge.
    assign push      = rx.frame_valid && frame_ok && !full;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state     <= IDLE;
            baud      <= '0;
            idx       <= '0;
            sh        <= '0;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_d;
            baud      <= baud_d;
            idx       <= idx_d;
            sh        <= sh_d;
            o_uart_tx <= tx_d;
            o_busy    <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud;
        idx_d   = idx;
        sh_d    = sh;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = mem[rd_ptr[FIFO_AW-1:0]];
                    baud_d  = RELOAD;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud == '0) begin
                    baud_d  = RELOAD;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud - TIMER_BITS'(1);
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_d = RELOAD;
                    if (idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx + 3'd1;
                        sh_d  = {1'b0, sh[7:1]};
                    end
                end else begin
                    baud_d = baud - TIMER_BITS'(1);
                end
            end
            STOP: begin
                if (baud == '0) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = mem[rd_ptr[FIFO_AW-1:0]];
                        baud_d  = RELOAD;
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud - TIMER_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= rx.frame[8:1];
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_frame_err <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
            if (rx.frame_valid && frame_ok && full) o_overflow <= 1'b1;
            if (rx.frame_valid && frame_bad && (o_frame_err != 8'hFF))
                o_frame_err <= o_frame_err + 8'd1;
        end
    end

    assign o_fifo_count = count;
    assign o_state      = state;
endmodule

// File: tb/tb_tx_uart_echo.sv
// Bench for tx_uart_echo: frame-level reference model plus a serial-line monitor
// that decodes each transmitted frame and checks it against the expected byte queue.
module tb_tx_uart_echo;
    localparam int CPB        = 4;
    localparam int AW         = 4;
    localparam int DEPTH      = 16;
    localparam int FRAME_CLKS = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_tx, busy, overflow;
    logic [AW:0] fifo_count;
    logic [7:0]  frame_err;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    tx_uart_echo_if fif ();

    tx_uart_echo #(
        .TIMER_BITS      (10),
        .CLOCKS_PER_BAUD (CPB),
        .FIFO_AW         (AW)
    ) dut (
        .clk          (clk),
        .i_reset      (rst),
        .rx           (fif),
        .o_uart_tx    (uart_tx),
        .o_busy       (busy),
        .o_fifo_count (fifo_count),
        .o_overflow   (overflow),
        .o_frame_err  (frame_err),
        .o_state      (state_dbg)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            if (mismatched <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, transmitter as "clocks left in current frame".
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         rem      = 0;
    logic [7:0] cur      = '0;
    bit         m_ovf    = 0;
    int         m_ferr   = 0;
    int         rst_epoch = 0;
    bit         chk_en   = 0;
    int         m_cnt;
    bit         m_pop;
    bit         m_push;
    logic [9:0] m_f;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            rem    = 0;
            cur    = '0;
            m_ovf  = 0;
            m_ferr = 0;
            rst_epoch++;
            chk_en = 1;
        end else begin
            m_cnt  = mq.size();
            m_pop  = (rem <= 1) && (m_cnt > 0);
            m_push = 0;
            m_f    = fif.frame;
            if (fif.frame_valid && m_f != 10'h3FF) begin
                if (m_f[0] != 1'b0 || m_f[9] != 1'b1) begin
                    if (m_ferr < 255) m_ferr++;
                end else if (m_cnt < DEPTH) begin
                    m_push = 1;
                end else begin
                    m_ovf = 1;
                end
            end
            if (m_pop) begin
                cur = mq.pop_front();
                exp_q.push_back(cur);
                rem = FRAME_CLKS;
            end else if (rem > 0) begin
                rem--;
            end
            if (m_push) mq.push_back(m_f[8:1]);
        end
    end

    logic [9:0] line_bits;
    int         exp_line;

    always @(negedge clk) begin
        if (chk_en) begin
            line_bits = {1'b1, cur, 1'b0};
            exp_line  = (rem > 0) ? int'(line_bits[(FRAME_CLKS - rem) / CPB]) : 1;
            check("uart_tx",    int'(uart_tx),    exp_line);
            check("busy",       int'(busy),       (rem > 0) ? 1 : 0);
            check("fifo_count", int'(fifo_count), mq.size());
            check("overflow",   int'(overflow),   int'(m_ovf));
            check("frame_err",  int'(frame_err),  m_ferr);
        end
    end

    // Serial monitor: samples each bit mid-cell and pops the expected byte.
    logic [9:0] mon_bits;
    logic [7:0] mon_e;
    int         mon_ep;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst && uart_tx == 1'b0) begin
                mon_ep = rst_epoch;
                repeat (2) @(negedge clk);
                mon_bits[0] = uart_tx;
                for (int k = 1; k < 10; k++) begin
                    repeat (CPB) @(negedge clk);
                    mon_bits[k] = uart_tx;
                end
                if (mon_ep == rst_epoch) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL tx_frame at %0t: got frame %0h, expected no frame", $time, mon_bits);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("tx_frame", int'(mon_bits), int'({1'b1, mon_e, 1'b0}));
                    end
                end
            end
        end
    end

    task automatic send(input logic [9:0] f);
        fif.frame_valid = 1'b1;
        fif.frame       = f;
        @(negedge clk);
        fif.frame_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while ((mq.size() != 0 || rem != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout at %0t: waited %0d cycles, required idle within 3000", $time, t);
        end
        idle(5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int         kind;
    logic [7:0] rb;

    initial begin
        fif.frame_valid = 1'b0;
        fif.frame       = '0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);

        send({1'b1, 8'hA5, 1'b0});
        drain();

        send(10'h3FF);
        idle(20);

        send({1'b0, 8'h55, 1'b0});
        idle(20);

        for (int i = 0; i < 18; i++) send({1'b1, 8'(i), 1'b0});
        drain();

        for (int i = 0; i < 4; i++) send({1'b1, 8'(48 + i), 1'b0});
        idle(18);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(60);

        repeat (300) send(10'h201);
        idle(5);

        repeat (250) begin
            kind = $urandom_range(0, 9);
            rb   = 8'($urandom_range(0, 255));
            case (kind)
                0:       send(10'h3FF);
                1:       send({1'b0, rb, 1'b0});
                2:       send({1'b1, rb, 1'b1});
                3:       send(10'($urandom_range(0, 1023)));
                default: send({1'b1, rb, 1'b0});
            endcase
            idle($urandom_range(0, 50));
        end
        drain();

        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
